// File: rtl/cla_serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
//   Shared definitions for the nibble-serial add/subtract sequencer.
//   - NIBBLE_W    : width of the single lookahead slice (4 bits)
//   - cla_state_t : controller states IDLE / RUN / DONE
//   - cnt_width() : width of the nibble counter for a given nibble count
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_t;

  // Counter only needs to reach nibbles-1, so $clog2(nibbles) bits suffice.
  function automatic int cnt_width(input int nibbles);
    return $clog2(nibbles);
  endfunction

endpackage

// File: rtl/cla_serial_add_ctrl_nibble_slice.sv
// ---------------------------------------------------------------------------
// cla_nibble_slice
//   Purely combinational 4-bit carry-lookahead slice.
//   Ports:
//     a, b  in  [3:0]  nibble operands
//     cin   in         carry into bit 0
//     sum   out [3:0]  nibble sum
//     c3    out        internal carry into bit 3 (used for signed overflow)
//     pg    out        group propagate (all four bits propagate)
//     gg    out        group generate (nibble generates a carry by itself)
//   The nibble carry-out is gg | (pg & cin); the consumer forms it from the
//   group terms so the same pair can feed a higher lookahead level.
// ---------------------------------------------------------------------------
module cla_nibble_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c3,
  output logic                pg,
  output logic                gg
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic                c1;
  logic                c2;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLE_W; gi++) begin : g_pg_bits
      assign g[gi] = a[gi] & b[gi];
      assign p[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  // Flattened lookahead: every carry is a sum of products of g/p/cin.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// cla_serial_add_ctrl
//   Nibble-serial add/subtract sequencer. One WIDTH-bit operation is accepted
//   over a valid/ready handshake and stepped through a single 4-bit lookahead
//   slice, LSB nibble first, with the carry registered between nibbles. The
//   result is returned over a valid/ready handshake NIBBLES edges later.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   operation handshake (in_ready only in IDLE)
//     a, b                operands, sampled on the accept edge
//     sub, cin            1 = A-B (cin ignored), 0 = A+B+cin
//     out_valid/out_ready result handshake
//     sum, cout, ovf      result, MSB carry-out (sub: 1 = no borrow), overflow
//     busy                high in RUN or DONE
//     zero, neg           (only with CLA_FLAGS_EN) sum == 0, sum sign bit
//
//   Optional feature macro: CLA_FLAGS_EN adds the zero/neg flag outputs.
// ---------------------------------------------------------------------------
module cla_serial_add_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
`ifdef CLA_FLAGS_EN
  output logic             zero,
  output logic             neg,
`endif
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  cla_state_t state_reg;
  cla_state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic             accept;
  logic             last_nibble;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_c3;
  logic                slice_pg;
  logic                slice_gg;
  logic                slice_cout;

  cla_nibble_slice u_slice (
    .a   (a_reg[NIBBLE_W-1:0]),
    .b   (b_reg[NIBBLE_W-1:0]),
    .cin (carry_reg),
    .sum (slice_sum),
    .c3  (slice_c3),
    .pg  (slice_pg),
    .gg  (slice_gg)
  );

  assign slice_cout = slice_gg | (slice_pg & carry_reg);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    last_nibble = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == LAST_CNT) begin
          last_nibble = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B here and force the carry-in.
      a_reg     <= a;
      b_reg     <= b ^ {WIDTH{sub}};
      carry_reg <= sub ? 1'b1 : cin;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> NIBBLE_W;
      b_reg     <= b_reg >> NIBBLE_W;
      carry_reg <= slice_cout;
      cnt_reg   <= cnt_reg + CNT_W'(1);
      // Shifting in from the top leaves nibble 0 at the bottom after the
      // final step.
      sum_reg   <= {slice_sum, sum_reg[WIDTH-1:NIBBLE_W]};
      if (last_nibble) begin
        cout_reg <= slice_cout;
        ovf_reg  <= slice_c3 ^ slice_cout;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

`ifdef CLA_FLAGS_EN
  logic zero_acc_reg;
  logic zero_reg;
  logic neg_reg;

  // zero_acc_reg is a sticky "every nibble so far was zero" bit; combined
  // with the final nibble it gives sum == 0 without a full-width compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc_reg <= 1'b0;
      zero_reg     <= 1'b0;
      neg_reg      <= 1'b0;
    end else if (accept) begin
      zero_acc_reg <= 1'b1;
    end else if (state_reg == RUN) begin
      zero_acc_reg <= zero_acc_reg & (slice_sum == '0);
      if (last_nibble) begin
        zero_reg <= zero_acc_reg & (slice_sum == '0);
        neg_reg  <= slice_sum[NIBBLE_W-1];
      end
    end
  end

  assign zero = zero_reg;
  assign neg  = neg_reg;
`endif

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cla_serial_add_ctrl
//   Scoreboard bench: the stimulus process pushes the hand-computed result of
//   each operation; a monitor pops one entry when out_valid rises and compares
//   it on every cycle out_valid stays high (so held results must stay stable).
// ---------------------------------------------------------------------------
module tb_cla_serial_add_ctrl;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
`ifdef CLA_FLAGS_EN
  logic             zero;
  logic             neg;
`endif

  cla_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
`ifdef CLA_FLAGS_EN
    .zero      (zero),
    .neg       (neg),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t cur;
  logic have_cur = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur = 1'b0;
    end else if (out_valid) begin
      if (!have_cur) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum 0x%0h with no operation pending", sum);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          chk("latency", 32'(cyc - accept_cyc), 32'(NIBBLES));
        end
      end
      if (have_cur) begin
        chk("sum", 32'(sum), 32'(cur.sum));
        chk("cout", 32'(cout), 32'(cur.cout));
        chk("ovf", 32'(ovf), 32'(cur.ovf));
`ifdef CLA_FLAGS_EN
        chk("zero", 32'(zero), 32'(cur.zero));
        chk("neg", 32'(neg), 32'(cur.neg));
`endif
        $display("result sum=0x%04h cout=%0d ovf=%0d (expected 0x%04h %0d %0d)",
                 sum, cout, ovf, cur.sum, cur.cout, cur.ovf);
      end
    end else begin
      have_cur = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic s, input logic c,
                       input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                       input logic ez, input logic en);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    a = av; b = bv; sub = s; cin = c; in_valid = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo; e.zero = ez; e.neg = en;
    exp_q.push_back(e);
    accept_cyc = cyc + 1;
    $display("issue a=0x%04h b=0x%04h sub=%0d cin=%0d", av, bv, s, c);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Waits for out_valid, checking in_ready stays low meanwhile.
  task automatic wait_result();
    int n = 0;
    while (!out_valid && n < 20) begin
      chk("in_ready_run", 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
    chk("in_ready_done", 32'(in_ready), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed vectors: a, b, sub, cin -> sum, cout, ovf, zero, neg
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_result(); @(negedge clk);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_result(); @(negedge clk);
    issue(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_result(); @(negedge clk);
    issue(16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_result(); @(negedge clk);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_result(); @(negedge clk);
    issue(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_result(); @(negedge clk);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_result(); @(negedge clk);

    // Backpressure: result must hold while operands/in_valid wiggle.
    out_ready = 1'b0;
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_result();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 16'($urandom);
      b = 16'($urandom);
      sub = ~sub;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    issue(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_result(); @(negedge clk);

    // Asynchronous reset after two nibbles have been processed.
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
`ifdef CLA_FLAGS_EN
    chk("abort_zero", 32'(zero), 32'd0);
    chk("abort_neg", 32'(neg), 32'd0);
`endif
    $display("reset asserted mid-run, pending result discarded");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_result(); @(negedge clk);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cla_serial_add_ctrl.md
Name: cla_serial_add_ctrl

Overview:
- Nibble-serial add/subtract sequencer.
- Accepts one WIDTH-bit operation over a valid/ready handshake.
- Steps it through a single 4-bit carry-lookahead slice, one nibble per clock, LSB first, with the carry registered between nibbles.
- Returns the sum and flags over a valid/ready result handshake.
- Lets wide adds share one small lookahead slice instead of a full-width adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived nibble count; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operation request
- in_ready  output  1  high when the block can accept an operation (IDLE only)
- a  input  WIDTH  operand A, sampled on the accept edge
- b  input  WIDTH  operand B, sampled on the accept edge
- sub  input  1  1 = A - B, 0 = A + B + cin
- cin  input  1  carry-in for add; ignored when sub=1
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB (for sub: 1 = no borrow)
- ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- States:
  - IDLE: in_ready=1.
  - RUN: processes one nibble per cycle.
  - DONE: out_valid=1.
- Reset (async, rst_n=0): state IDLE; sum=0, cout=0, ovf=0, out_valid=0, busy=0; nibble counter=0; carry register=0; operand registers cleared. in_ready=1 from the first cycle after reset deasserts.
- Accept: rising edge with in_valid & in_ready.
  - Latches a, b^{WIDTH{sub}} and carry = sub ? 1 : cin.
  - Counter cleared; state -> RUN.
- RUN, per cycle:
  - Slice inputs: the low nibble of the operand registers and the carry register.
  - At the edge: the slice's 4-bit sum is shifted into sum from the top; operand registers shift right by 4; carry register <= slice carry-out; counter increments.
  - At the edge where counter = NIBBLES-1: capture cout = slice carry-out and ovf = slice internal carry into bit 3 XOR slice carry-out; state -> DONE.
- Latency: out_valid rises exactly NIBBLES clock edges after the accept edge (4 for WIDTH=16).
- DONE: sum, cout and ovf held stable while out_valid=1 & out_ready=0.
  - On an edge with out_ready=1: out_valid -> 0, state -> IDLE.
  - in_ready stays 0 in DONE, so there is one bubble cycle between results.
- in_valid outside IDLE is ignored; operands are not resampled.
- sum is updated in place during RUN; it is only meaningful while out_valid=1.
- Reset asserted mid-RUN or in DONE aborts immediately. Partial results are discarded; outputs go to their reset values.
- Carry chain: a carry generated in nibble k must reach nibble k+1 via the register. The 0xFFFF+1 case must propagate through all nibbles.
- busy = (state != IDLE).

Optional Feature:
- Macro: CLA_FLAGS_EN.
- Defined: adds outputs zero (1 bit, sum == 0) and neg (1 bit, sum[WIDTH-1]).
  - Both are registered at the same edge as the final nibble.
  - Both are held with sum, and reset to 0.
- zero is tracked incrementally: a sticky "all nibbles zero so far" bit, cleared on accept-edge reload. No WIDTH-wide compare.
- Undefined: no zero/neg ports and no tracking logic; the remaining behaviour is identical.

Decomposition:
- Shared package cla_pkg:
  - NIBBLE_W = 4.
  - State typedef cla_state_t {IDLE, RUN, DONE}.
  - Function computing the NIBBLES counter width, $clog2(NIBBLES).
- One sub-module, cla_nibble_slice (combinational):
  - Per-bit G = a&b, P = a^b.
  - Two-level lookahead carries c1..c3 and cout; sum = P ^ {c3,c2,c1,cin}.
  - Exports c3 (for ovf) and group PG/GG.
- The controller instantiates exactly one slice.

Test Plan (WIDTH=16):
- Add 0x1234+0x4321, cin=0 -> sum 0x5555, cout 0, ovf 0; out_valid exactly 4 edges after accept; in_ready 0 during RUN/DONE.
- Add 0xFFFF+0x0001, cin=0 -> sum 0x0000, cout 1, ovf 0 (carry ripples through all four nibble steps). With CLA_FLAGS_EN: zero 1, neg 0.
- Sub 0x8000-0x0001 with cin=1 (must be ignored) -> sum 0x7FFF, cout 1, ovf 1. Sub 0x0001-0x0002 -> sum 0xFFFF, cout 0, ovf 0, neg 1 (if enabled).
- Add 0x7FFF+0x0001 -> sum 0x8000, cout 0, ovf 1. Add 0x0000+0x0000 with cin=1 -> sum 0x0001.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, toggle in_valid and operands meanwhile -> sum/flags stable, in_ready 0, no new accept; out_ready=1 -> IDLE next edge; next operation correct.
- Pull rst_n low asynchronously mid-RUN (after 2 nibbles) -> outputs immediately at reset values, busy 0; after release, 0x00FF+0x0001 -> 0x0100.
